sd_sector_arbiter: RTL
======================

// Module: sd_sector_arbiter
// PURPOSE
//  Shares the single sd_card sector-read port between NREQ requesters (FDC drive A, FDC drive B, ACSI/hard disk).
//  Round-robin grant; one sector transaction in flight at a time.
//  Each transaction carries an image slot and an LBA. Sector bytes are routed to the owning requester only.
//  Timeouts protect against a stalled card. Sits in the top level between the atarist core and sd_card.
// PARAMETERS
//  NREQ     3            number of requesters (2..8)
//  TIMEOUT  32'd3200000  max cycles waiting for rbusy rise or rdone (100 ms @ 32 MHz)
// PORTS
//  clk          in   1        system clock (clk_32 domain); single clock
//  reset        in   1        synchronous, active-high reset
//  req_rd       in   NREQ     level read request per requester, held until req_done/req_err
//  req_img      in   2*NREQ   one-hot image slot per requester ([2i+1:2i])
//  req_lba      in   32*NREQ  sector LBA per requester ([32i+31:32i])
//  req_busy     out  NREQ     high while the requester's transaction is active (acts as ack)
//  req_done     out  NREQ     1-cycle pulse: sector fully delivered
//  req_err      out  NREQ     1-cycle pulse: invalid image slot or timeout
//  req_strobe   out  NREQ     byte-valid strobe, owner bit only
//  req_addr     out  9        byte index 0..511 (shared)
//  req_data     out  8        sector byte (shared)
//  grant        out  NREQ     one-hot current owner, 0 when idle
//  sd_rstart    out  2        to sd_card rstart (one-hot image slot)
//  sd_rsector   out  32       to sd_card rsector
//  sd_rbusy     in   1        from sd_card rbusy
//  sd_rdone     in   1        from sd_card rdone (pulse)
//  sd_outen     in   1        from sd_card outen
//  sd_outaddr   in   9        from sd_card outaddr
//  sd_outbyte   in   8        from sd_card outbyte
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; RR pointer = 0; timer = 0. Reset mid-transaction drops sd_rstart on the next edge.
//  States and transitions:
//   IDLE: pick the first requester with req_rd=1, searching from the RR pointer upward with wrap.
//    Register grant, sd_rsector, sd_rstart <= req_img; set req_busy[owner].
//    Pointer <= owner+1 (mod NREQ). Latency from req_rd to req_busy/grant is 1 cycle.
//    If req_img is not one-hot (00 or 11): go to ERR and never touch sd_rstart.
//   START: hold sd_rstart and sd_rsector until sd_rbusy=1, then go to BUSY.
//    If timer reaches TIMEOUT, go to ERR.
//   BUSY: drop sd_rstart.
//    Each cycle: req_strobe[owner] = sd_outen, req_addr = sd_outaddr, req_data = sd_outbyte.
//    These outputs are registered, so they lag sd_card by 1 cycle.
//    sd_rdone, or an sd_rbusy fall without rdone: go to DONE. TIMEOUT: go to ERR.
//   DONE: pulse req_done[owner] for 1 cycle (this is 1 cycle after the last strobe); clear req_busy and grant.
//    Go to GAP.
//   ERR: pulse req_err[owner]; clear sd_rstart, req_busy and grant. Go to GAP.
//   GAP: 1 cycle, so the requester can drop req_rd.
//    Wait for sd_rbusy=0 before returning to IDLE (no back-to-back overlap).
//  Timer: reset on every state entry; counts saturating to TIMEOUT.
//  Owner drops req_rd mid-transaction: the transaction runs to completion (sd_card cannot abort).
//   Strobes and done are still issued.
//  req_lba/req_img changing after grant is ignored; the values are latched in IDLE.
//  sd_outen outside BUSY is ignored and no strobe is emitted.
//  Exactly one transaction is in flight. Non-owners see busy=0, strobe=0, done=0.
//  Simultaneous requests: the RR order gives fairness. A requester waits at most NREQ-1 transactions.
// STRUCTURE
//  sd_arb_pkg: state enum (IDLE, START, BUSY, DONE, ERR, GAP), TIMER_W, SECTOR_BYTES=512.
//  Sub-module rr_arbiter #(N): req vector and pointer in -> one-hot grant plus index (combinational).
//   Instantiated once.
//  Top: FSM, latches, timer, output routing registers.
// TESTING
//  1. Single request: req0 img=01 lba=0x10. Expect: busy0 after 1 cycle; sd_rstart=01 until rbusy.
//     Then 512 strobes on strobe0 with addr 0..511; done0 pulse; grant returns to 0.
//  2. req0/req1/req2 all high at once. Expect grant order 0,1,2.
//     Then with req0 and req2 held high: order 0,2,0,2 (round-robin wrap).
//  3. Invalid slot: req1 img=00. Expect: err1 pulse within 2 cycles, sd_rstart never asserted, then IDLE.
//  4. Card stalls: sd_rbusy never rises, TIMEOUT=100. Expect: err0 at about cycle 101, sd_rstart cleared.
//  5. reset asserted on byte 200 of a transfer. Expect: all outputs 0 next cycle.
//     A new request is granted only after sd_rbusy falls.
//  6. Owner drops req_rd mid-sector. Expect: the remaining strobes and done still go to the owner.
//     No other requester is granted until GAP is done.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the sd sector arbiter
package sd_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_ERR,
        S_GAP
    } state_t;

    localparam int TIMER_W      = 32;
    localparam int SECTOR_BYTES = 512;
    localparam int ADDR_W       = $clog2(SECTOR_BYTES);

    // sd_card expects exactly one image slot bit in rstart
    function automatic logic img_onehot(input logic [1:0] img);
        return img[0] ^ img[1];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW:0]   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            cand_idx = cand[IW-1:0];
            if (!valid_o && req_i[cand_idx]) begin
                valid_o         = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin sharing of the sd_card sector-read port
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ    = 3,
    parameter logic [31:0] TIMEOUT = 32'd3200000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_rd,
    input  logic [2*NREQ-1:0]   req_img,
    input  logic [32*NREQ-1:0]  req_lba,
    output logic [NREQ-1:0]     req_busy,
    output logic [NREQ-1:0]     req_done,
    output logic [NREQ-1:0]     req_err,
    output logic [NREQ-1:0]     req_strobe,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [7:0]          req_data,
    output logic [NREQ-1:0]     grant,
    output logic [1:0]          sd_rstart,
    output logic [31:0]         sd_rsector,
    input  logic                sd_rbusy,
    input  logic                sd_rdone,
    input  logic                sd_outen,
    input  logic [ADDR_W-1:0]   sd_outaddr,
    input  logic [7:0]          sd_outbyte
);

    localparam int IW = $clog2(NREQ);

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [NREQ-1:0]     grant_q, busy_q, done_q, err_q, strobe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          data_q;
    logic [1:0]          rstart_q;
    logic [31:0]         rsector_q;

    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;
    logic [1:0]          arb_img;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req_i   (req_rd),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign arb_img = req_img[2*arb_idx +: 2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            timer_q   <= '0;
            grant_q   <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            strobe_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rstart_q  <= '0;
            rsector_q <= '0;
        end else begin
            done_q   <= '0;
            err_q    <= '0;
            strobe_q <= '0;
            if (timer_q != TIMEOUT) begin
                timer_q <= timer_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    // a card still busy from an earlier (possibly reset-aborted) read blocks new grants
                    if (arb_valid && !sd_rbusy) begin
                        grant_q   <= arb_gnt;
                        busy_q    <= arb_gnt;
                        rsector_q <= req_lba[32*arb_idx +: 32];
                        ptr_q     <= (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
                        timer_q   <= '0;
                        if (img_onehot(arb_img)) begin
                            rstart_q <= arb_img;
                            state_q  <= S_START;
                        end else begin
                            state_q  <= S_ERR;
                        end
                    end
                end
                S_START: begin
                    if (sd_rbusy) begin
                        rstart_q <= '0;
                        state_q  <= S_BUSY;
                        timer_q  <= '0;
                    end else if (timer_q == TIMEOUT) begin
                        state_q  <= S_ERR;
                        timer_q  <= '0;
                    end
                end
                S_BUSY: begin
                    strobe_q <= grant_q & {NREQ{sd_outen}};
                    addr_q   <= sd_outaddr;
                    data_q   <= sd_outbyte;
                    // byte activity counts as progress, so only a silent card trips the timeout
                    if (sd_outen) begin
                        timer_q <= '0;
                    end
                    if (sd_rdone || !sd_rbusy) begin
                        done_q  <= grant_q;
                        busy_q  <= '0;
                        grant_q <= '0;
                        state_q <= S_DONE;
                        timer_q <= '0;
                    end else if (timer_q == TIMEOUT) begin
                        state_q <= S_ERR;
                        timer_q <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_GAP;
                    timer_q <= '0;
                end
                S_ERR: begin
                    err_q    <= grant_q;
                    busy_q   <= '0;
                    grant_q  <= '0;
                    rstart_q <= '0;
                    state_q  <= S_GAP;
                    timer_q  <= '0;
                end
                S_GAP: begin
                    if (!sd_rbusy) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_busy   = busy_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign req_strobe = strobe_q;
    assign req_addr   = addr_q;
    assign req_data   = data_q;
    assign grant      = grant_q;
    assign sd_rstart  = rstart_q;
    assign sd_rsector = rsector_q;

endmodule
